// File: rtl/hm_operand_sequencer_if.sv
// Handshake bundle between the ciphertext buffer, the operand sequencer and the multiplier.
// master = sequencer side, slave = buffer/multiplier/consumer side.
interface hm_operand_sequencer_if #(
    parameter int CIPHERTEXT_WIDTH = 21,
    parameter int DIM_WIDTH        = 2,
    parameter int PARALLEL         = 2
);
    logic                                      start;
    logic                                      busy;
    logic                                      in_valid;
    logic                                      in_ready;
    logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] in_data;
    logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] hm_op1;
    logic [DIM_WIDTH:0]                        hm_row;
    logic                                      hm_ciphertext_select;
    logic                                      hm_en;
    logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] hm_result;
    logic                                      res_valid;
    logic                                      res_ready;
    logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] res_data;
    logic                                      res_last;

    modport master (
        input  start, in_valid, in_data, hm_result, res_ready,
        output busy, in_ready, hm_op1, hm_row, hm_ciphertext_select, hm_en,
               res_valid, res_data, res_last
    );

    modport slave (
        output start, in_valid, in_data, hm_result, res_ready,
        input  busy, in_ready, hm_op1, hm_row, hm_ciphertext_select, hm_en,
               res_valid, res_data, res_last
    );
endinterface

// File: rtl/hm_operand_sequencer.sv
// Front-end for homomorphic_multiply: streams two ciphertexts into the multiplier, then
// collects the product beats into a small FIFO and re-emits them as a valid/ready stream.
module hm_operand_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 21,
    parameter int DIMENSION        = 3,
    parameter int DIM_WIDTH        = 2,
    parameter int PARALLEL         = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hm_operand_sequencer_if.master bus
);
    localparam int LOAD_BEATS = (DIMENSION + 1 + PARALLEL - 1) / PARALLEL;
    localparam int OUT_LEN    = 2 * DIMENSION + 1;
    localparam int OUT_BEATS  = (OUT_LEN + PARALLEL - 1) / PARALLEL;
    localparam int CNT_W      = $clog2(OUT_BEATS) + 1;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int ROW_W      = DIM_WIDTH + 1;

    typedef logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] beat_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_DRAIN, S_WAIT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, pop_cnt;
    logic              last_load, credit_ok;
    logic              issue, issue_sel, issue_prod, in_ready_c, busy_c;
    beat_t             issue_data;
    logic [ROW_W-1:0]  issue_row;

    logic              hm_en_q, hm_sel_q;
    beat_t             hm_op1_q;
    logic [ROW_W-1:0]  hm_row_q;
    logic              en_prod, cap_v;

    beat_t             mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic              res_valid_c, pop;

    assign last_load = (cnt == CNT_W'(LOAD_BEATS - 1));
    assign issue_row = ROW_W'(int'(cnt) * PARALLEL);
    // Beats already on the multiplier (en_prod) or awaiting capture (cap_v) own a FIFO slot.
    assign credit_ok = (int'(fifo_cnt) + int'(en_prod) + int'(cap_v)) < FIFO_DEPTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.start) state_nx = S_LOAD_A;
            S_LOAD_A: if (issue && last_load) state_nx = S_LOAD_B;
            S_LOAD_B: if (issue && last_load)
                          state_nx = (OUT_BEATS > LOAD_BEATS) ? S_DRAIN : S_WAIT;
            S_DRAIN:  if (issue && cnt == CNT_W'(OUT_BEATS - 1)) state_nx = S_WAIT;
            S_WAIT:   if (pop_cnt == CNT_W'(OUT_BEATS)) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        issue      = 1'b0;
        issue_sel  = 1'b0;
        issue_prod = 1'b0;
        issue_data = '0;
        busy_c     = (state != S_IDLE);
        case (state)
            S_LOAD_A: begin
                in_ready_c = 1'b1;
                issue      = bus.in_valid;
                issue_data = bus.in_data;
            end
            S_LOAD_B: begin
                in_ready_c = credit_ok;
                issue      = bus.in_valid & credit_ok;
                issue_sel  = 1'b1;
                issue_prod = 1'b1;
                issue_data = bus.in_data;
            end
            S_DRAIN: begin
                issue      = credit_ok;
                issue_prod = 1'b1;
            end
            default: ;
        endcase
    end

    // Issue registers, capture pipeline and beat counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hm_en_q  <= 1'b0;
            hm_op1_q <= '0;
            hm_row_q <= '0;
            hm_sel_q <= 1'b0;
            en_prod  <= 1'b0;
            cap_v    <= 1'b0;
            cnt      <= '0;
            pop_cnt  <= '0;
        end else begin
            hm_en_q  <= issue;
            hm_op1_q <= issue ? issue_data : '0;
            en_prod  <= issue & issue_prod;
            cap_v    <= en_prod;
            if (issue) begin
                hm_row_q <= issue_row;
                hm_sel_q <= issue_sel;
            end
            if (state == S_IDLE) begin
                cnt <= '0;
            end else if (issue) begin
                // LOAD_B hands the count to DRAIN so product rows continue past the load.
                if (state != S_DRAIN && last_load)
                    cnt <= (state == S_LOAD_B) ? CNT_W'(LOAD_BEATS) : '0;
                else
                    cnt <= cnt + 1'b1;
            end
            if (state == S_IDLE)  pop_cnt <= '0;
            else if (pop)         pop_cnt <= pop_cnt + 1'b1;
        end
    end

    assign res_valid_c = (fifo_cnt != '0);
    assign pop         = res_valid_c & bus.res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (cap_v) begin
                mem[wr_ptr] <= bus.hm_result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({cap_v, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Coefficients past the product length are zeroed on the final partial beat.
    for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
        assign bus.res_data[l] = (res_valid_c && (int'(pop_cnt) * PARALLEL + l) < OUT_LEN)
                                 ? mem[rd_ptr][l] : '0;
    end

    assign bus.busy                 = busy_c;
    assign bus.in_ready             = in_ready_c;
    assign bus.hm_en                = hm_en_q;
    assign bus.hm_op1               = hm_op1_q;
    assign bus.hm_row               = hm_row_q;
    assign bus.hm_ciphertext_select = hm_sel_q;
    assign bus.res_valid            = res_valid_c;
    assign bus.res_last             = res_valid_c && (pop_cnt == CNT_W'(OUT_BEATS - 1));
endmodule

// File: tb/tb_hm_operand_sequencer.sv
// Scoreboard bench: expected issues and product beats are queued at stimulus time and
// compared as the sequencer drives the multiplier model and pops results.
module tb_hm_operand_sequencer;
    localparam int CW = 21, D = 3, DW = 2, P = 2, FD = 4;
    localparam int LB = (D + 1 + P - 1) / P;
    localparam int OL = 2 * D + 1;
    localparam int OB = (OL + P - 1) / P;
    localparam int ROW_W = DW + 1;
    localparam logic [CW-1:0] JUNK = 21'h15555;
    localparam logic [CW-1:0] GARB = 21'h0abcd;

    typedef logic [P-1:0][CW-1:0] beat_t;
    typedef logic [CW-1:0] coef_arr_t [OB*P];

    logic clk, rst;
    int   n_chk = 0, n_fail = 0, n_iss = 0;
    logic [63:0] iss_q[$], exp_q[$];
    coef_arr_t sa, sb, ma, mb;
    int   mdl_n;
    logic pend;
    logic [ROW_W-1:0] prow;

    hm_operand_sequencer_if #(.CIPHERTEXT_WIDTH(CW), .DIM_WIDTH(DW), .PARALLEL(P)) bus ();

    hm_operand_sequencer #(
        .CIPHERTEXT_WIDTH(CW), .DIMENSION(D), .DIM_WIDTH(DW), .PARALLEL(P), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] conv(input coef_arr_t x, input coef_arr_t y, input int i);
        longint s = 0;
        for (int j = 0; j <= D; j++)
            if (i - j >= 0 && i - j <= D) s += longint'(x[j]) * longint'(y[i-j]);
        return CW'(s);
    endfunction

    function automatic logic [63:0] pk_iss(input int row, input logic sel, input beat_t d);
        return 64'({ROW_W'(row), sel, d});
    endfunction

    function automatic beat_t beat_of(input int k);
        beat_t d;
        int kk = (k < LB) ? k : k - LB;
        for (int l = 0; l < P; l++) begin
            int idx = kk * P + l;
            d[l] = (idx <= D) ? ((k < LB) ? sa[idx] : sb[idx]) : '0;
        end
        return d;
    endfunction

    // Multiplier model: one-cycle latency, junk on result_partial when nothing is due.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_n <= 0;
            pend  <= 1'b0;
            prow  <= '0;
        end else begin
            pend <= 1'b0;
            if (bus.hm_en) begin
                mdl_n <= (mdl_n == LB + OB - 1) ? 0 : mdl_n + 1;
                for (int l = 0; l < P; l++) begin
                    if (mdl_n < LB)                    ma[int'(bus.hm_row) + l] <= bus.hm_op1[l];
                    else if (bus.hm_ciphertext_select) mb[int'(bus.hm_row) + l] <= bus.hm_op1[l];
                end
                if (mdl_n >= LB) begin
                    pend <= 1'b1;
                    prow <= bus.hm_row;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < P; l++) begin
            if (!pend)                   bus.hm_result[l] = JUNK;
            else if (int'(prow) + l < OL) bus.hm_result[l] = conv(ma, mb, int'(prow) + l);
            else                         bus.hm_result[l] = GARB;
        end
    end

    // Monitor: every issue and every popped result is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.hm_en) begin
            n_iss++;
            if (iss_q.size() == 0) chk("issue_unexpected", 64'(1), 64'(0));
            else chk("issue", pk_iss(int'(bus.hm_row), bus.hm_ciphertext_select, bus.hm_op1),
                     iss_q.pop_front());
        end
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) chk("result_unexpected", 64'(1), 64'(0));
            else chk("result", 64'({bus.res_last, bus.res_data}), exp_q.pop_front());
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},     64'(bus.busy), 64'(0));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
        chk({tag, "_hm_en"},    64'(bus.hm_en), 64'(0));
        chk({tag, "_hm_op1"},   64'(bus.hm_op1), 64'(0));
        chk({tag, "_hm_row"},   64'(bus.hm_row), 64'(0));
        chk({tag, "_hm_sel"},   64'(bus.hm_ciphertext_select), 64'(0));
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
        chk({tag, "_res_data"}, 64'(bus.res_data), 64'(0));
        chk({tag, "_res_last"}, 64'(bus.res_last), 64'(0));
    endtask

    task automatic set_data(input bit rnd);
        for (int i = 0; i < OB * P; i++) begin
            sa[i] = (i <= D) ? (rnd ? CW'($urandom_range(0, 15)) : CW'(1)) : '0;
            sb[i] = (i <= D) ? (rnd ? CW'($urandom_range(0, 15)) : CW'(1)) : '0;
        end
    endtask

    // One multiply; rst_at >= 0 pulses reset just before that input beat and abandons it.
    task automatic do_mult(input bit bub, input bit xstart, input int rst_at);
        bit ok;
        for (int k = 0; k < LB; k++) iss_q.push_back(pk_iss(k * P, 1'b0, beat_of(k)));
        for (int k = 0; k < LB; k++) iss_q.push_back(pk_iss(k * P, 1'b1, beat_of(LB + k)));
        for (int k = LB; k < OB; k++) iss_q.push_back(pk_iss(k * P, 1'b0, '0));
        for (int k = 0; k < OB; k++) begin
            beat_t e;
            for (int l = 0; l < P; l++) e[l] = (k * P + l < OL) ? conv(sa, sb, k * P + l) : '0;
            exp_q.push_back(64'({k == OB - 1, e}));
        end
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int k = 0; k < 2 * LB; k++) begin
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1 chk_zero("midrst");
                iss_q.delete();
                exp_q.delete();
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            if (bub) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = beat_of(k);
            if (xstart && k == LB) bus.start = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = bus.in_ready;
            end
            if (!ok) chk("in_ready_timeout", 64'(0), 64'(1));
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            bus.start    = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = !bus.busy;
        end
        if (!ok) chk("busy_timeout", 64'(0), 64'(1));
        chk("iss_q_empty", 64'(iss_q.size()), 64'(0));
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("busy_drop", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;

        set_data(1'b0);
        do_mult(1'b0, 1'b0, -1);          // basic
        do_mult(1'b1, 1'b0, -1);          // input bubbles

        base = n_iss;                     // backpressure
        fork
            begin
                bus.res_ready = 1'b0;
                repeat (20) @(posedge clk);
                chk("bp_issues", 64'(n_iss - base), 64'(LB + OB));
                chk("bp_fifo_held", 64'(bus.res_valid), 64'(1));
                chk("bp_exp_pending", 64'(exp_q.size()), 64'(OB));
                #1 bus.res_ready = 1'b1;
            end
            do_mult(1'b0, 1'b0, -1);
        join

        do_mult(1'b0, 1'b0, LB + 1);      // reset during LOAD_B
        chk("post_rst_busy", 64'(bus.busy), 64'(0));
        do_mult(1'b0, 1'b0, -1);

        set_data(1'b1);
        do_mult(1'b0, 1'b1, -1);          // extra start while busy
        repeat (3) @(negedge clk);
        chk("stray_start", 64'(bus.busy), 64'(0));

        set_data(1'b1);
        do_mult(1'b0, 1'b0, -1);          // back-to-back
        set_data(1'b1);
        do_mult(1'b1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
